sext_accum: RTL
===============

Name: sext_accum

Overview:
- Downstream consumer of the narrow sign-converted words produced by the sign/width conversion stage.
- Accepts IW-bit samples over a valid/ready handshake. Each sample is sign-extended or zero-extended per beat, according to a signedness flag.
- Accumulates N samples and emits one OW-bit two's-complement block sum, with saturating or wrapping overflow handling and an overflow flag.

Parameters:
- IW, 4, input sample width (>=1)
- OW, 12, output sum width, always interpreted as signed (>=2)
- N, 8, samples per block (>=1)
- SAT, 1, overflow policy: 1 = saturate, 0 = wrap (truncate to OW LSBs)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- in_data  input  IW  sample
- in_signed  input  1  1 = in_data is two's complement, 0 = unsigned; sampled with each beat
- out_valid  output  1  block sum valid
- out_ready  input  1  downstream accepts sum
- out_data  output  OW  block sum, two's complement
- out_ovf  output  1  exact sum fell outside the OW signed range; qualified by out_valid

Behaviour:
- Interface:
  - Single clock domain, clk.
  - rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - State = ACC, beat count = 0, accumulator = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - in_ready = 1 from the first cycle rst is low.
  - Beats presented while rst is high are ignored.
- Extension:
  - in_signed = 1: sign-extend in_data.
  - in_signed = 0: zero-extend in_data.
  - Target is the internal accumulator width AW = IW + 1 + clog2(N) + 1. This is sufficient that the exact sum never overflows internally.
- States:
  - ACC:
    - in_ready = 1, out_valid = 0.
    - A beat is accepted when in_valid && in_ready: acc += ext(in_data), count += 1.
    - On the N-th accepted beat, the final sum (including that beat) is converted and registered into out_data/out_ovf, and the block moves to HOLD.
    - out_valid rises the cycle after the N-th accept (latency 1).
  - HOLD:
    - in_ready = 0, out_valid = 1.
    - out_data and out_ovf hold stable until out_valid && out_ready.
    - On that transfer: acc and count clear, and the block returns to ACC. The next cycle has out_valid = 0 and in_ready = 1 (one-cycle bubble per block; no overlap).
- in_valid low in ACC inserts idle cycles; acc and count hold. Beats need not be contiguous.
- Overflow conversion, where S is the exact AW-bit sum:
  - If -2^(OW-1) <= S <= 2^(OW-1)-1: out_data = S[OW-1:0], out_ovf = 0.
  - Otherwise out_ovf = 1, and:
    - SAT = 1: out_data = max positive (01..1) if S > 0, or min negative (10..0) if S < 0.
    - SAT = 0: out_data = S[OW-1:0].
- N = 1: every accepted beat produces a sum; the block alternates ACC and HOLD.
- in_data and in_signed are don't-care when in_valid is low or in_ready is low.
- rst asserted mid-block (ACC or HOLD): the partial sum or pending output is discarded and all state returns to reset values on the next edge.
- out_ready high in ACC has no effect.

Test Plan (IW=4, OW=6, N=4 unless noted):
- Signed negatives: 4 beats of 4'hF, in_signed=1 -> one cycle after the 4th accept, out_valid=1, out_data=6'h3C (-4), out_ovf=0.
- Unsigned saturation, SAT=1: 4 beats of 4'hF, in_signed=0 -> S=60, out_data=6'h1F, out_ovf=1.
- Unsigned wrap, SAT=0: same stimulus -> out_data=6'h3C, out_ovf=1.
- Exact minimum: 4 beats of 4'h8, signed -> out_data=6'h20 (-32), out_ovf=0.
- Mixed signedness: 4'hF signed, 4'hF unsigned, 4'h0, 4'h0 -> out_data=6'h0E (14), out_ovf=0.
- Backpressure and gaps:
  - Stimulus: in_valid toggling 1/0, and out_ready low for 5 cycles.
  - Required: out_data stable while out_ready is low; in_ready=0 throughout HOLD; in_ready=1 the cycle after the transfer.
- Reset mid-block:
  - Stimulus: 2 beats of 4'h7, then rst for 1 cycle, then 4 beats of 4'h1 unsigned.
  - Required: out_data=6'h04, out_ovf=0; no output is produced for the aborted block.

Source files
------------

// File: rtl/sext_accum.sv
// Block accumulator: sign- or zero-extends each IW-bit beat, sums N beats and
// emits one OW-bit two's-complement total with saturate/wrap overflow handling.
//
// state | meaning
// ------+----------------------------------------------------------
// ACC   | accepting beats, accumulating the current block
// HOLD  | block sum presented on out_*, waiting for out_ready
module sext_accum #(
  parameter int IW  = 4,
  parameter int OW  = 12,
  parameter int N   = 8,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_ovf
);

  // Sign bit plus clog2(N) growth plus one spare keeps the exact sum in range.
  localparam int AW = IW + 1 + $clog2(N) + 1;
  localparam int WW = (AW > OW) ? AW : OW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;

  logic [AW-1:0]    ext;
  logic [AW-1:0]    sum;
  logic [WW-1:0]    s_wide;
  logic [WW-OW:0]   hi;
  logic [OW-1:0]    conv_data;
  logic             conv_ovf;
  logic             accept;

  // Exact sum and its conversion to the OW-bit signed output range.
  always_comb begin
    ext = in_signed ? {{(AW-IW){in_data[IW-1]}}, in_data}
                    : {{(AW-IW){1'b0}}, in_data};
    sum    = acc_q + ext;
    s_wide = WW'($signed(sum));
    // In range exactly when every bit from OW-1 upward matches the sign.
    hi       = s_wide[WW-1:OW-1];
    conv_ovf = ~((&hi) | ~(|hi));
    if (conv_ovf && (SAT != 0)) begin
      conv_data = s_wide[WW-1] ? {1'b1, {(OW-1){1'b0}}}
                               : {1'b0, {(OW-1){1'b1}}};
    end else begin
      conv_data = s_wide[OW-1:0];
    end
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = sum;
          if (cnt_q == LAST) begin
            state_d    = HOLD;
            out_data_d = conv_data;
            out_ovf_d  = conv_ovf;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC:     in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;

endmodule
